// File: rtl/branch_sequencer.sv
// Instruction fetch/sequencing front end of the 8-bit CPU.
// Conditional jumps (MD=11) are resolved here; every other instruction is handed to execute.
module branch_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flag_we,
  input  logic [7:0]        alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic              jump_taken
);

  // state   | meaning
  // IDLE    | parked, waiting for run
  // FETCH   | opcode read issued at pc
  // WAIT_I  | opcode returned, decode and evaluate jump condition
  // ISSUE   | non-jump presented to execute, waiting for instr_ready
  // FETCH_T | jump target read issued at pc+1
  // WAIT_T  | target returned, pc loaded from it
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_I,
    S_ISSUE,
    S_FETCH_T,
    S_WAIT_T
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO  = ADDR_W'(2);
  localparam logic [1:0]        MD_JUMP = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        instr_q, instr_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic              mem_rd_q, mem_rd_d;
  logic              instr_valid_q, instr_valid_d;
  logic              jump_taken_q, jump_taken_d;
  logic              cond_true;
  logic              advance;

  // Condition is evaluated on the opcode as it arrives, against the registered flags.
  always_comb begin
    case (mem_rdata[2:0])
      3'b000:  cond_true = 1'b0;
      3'b001:  cond_true = z_q;
      3'b010:  cond_true = n_q;
      3'b011:  cond_true = n_q | z_q;
      3'b100:  cond_true = 1'b1;
      3'b101:  cond_true = !z_q;
      3'b110:  cond_true = !n_q && !z_q;
      default: cond_true = !n_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    instr_d       = instr_q;
    z_d           = z_q;
    n_d           = n_q;
    mem_rd_d      = 1'b0;
    instr_valid_d = 1'b0;
    jump_taken_d  = 1'b0;
    advance       = 1'b0;

    if (flag_we) begin
      z_d = (alu_result == 8'h00);
      n_d = alu_result[7];
    end

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        ir_d = mem_rdata;
        if (mem_rdata[7:6] == MD_JUMP) begin
          if (cond_true) begin
            state_d    = S_FETCH_T;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q + PC_ONE;
          end else begin
            pc_d    = pc_q + PC_TWO;
            advance = 1'b1;
          end
        end else begin
          state_d       = S_ISSUE;
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_d    = pc_q + PC_ONE;
          advance = 1'b1;
        end else begin
          instr_d       = ir_q;
          instr_valid_d = 1'b1;
        end
      end
      S_FETCH_T: begin
        state_d      = S_WAIT_T;
        jump_taken_d = 1'b1;
      end
      S_WAIT_T: begin
        pc_d    = ADDR_W'(mem_rdata);
        advance = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: the next fetch uses the freshly updated pc.
    if (advance) begin
      if (run) begin
        state_d    = S_FETCH;
        mem_rd_d   = 1'b1;
        mem_addr_d = pc_d;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RST;
      mem_addr_q    <= '0;
      ir_q          <= 8'h00;
      instr_q       <= 8'h00;
      z_q           <= 1'b1;
      n_q           <= 1'b0;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      jump_taken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      instr_q       <= instr_d;
      z_q           <= z_d;
      n_q           <= n_d;
      mem_rd_q      <= mem_rd_d;
      instr_valid_q <= instr_valid_d;
      jump_taken_q  <= jump_taken_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign jump_taken  = jump_taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus a randomized program stream
// compared against an instruction-level timing model.
module tb_branch_sequencer;
  localparam int W = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic       flag_we = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [7:0] pc;
  logic       jump_taken;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] mem [0:255];
  logic [7:0] m_pc;

  int         rd_t[$];
  logic [7:0] rd_a[$];
  int         jt_t[$];
  int         is_t[$];
  logic [7:0] is_v[$];
  int         iv_cnt = 0;

  branch_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flag_we(flag_we), .alu_result(alu_result),
    .pc(pc), .jump_taken(jump_taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin rd_t.push_back(cyc); rd_a.push_back(mem_addr); end
      if (jump_taken) jt_t.push_back(cyc);
      if (instr_valid) iv_cnt++;
      if (instr_valid && instr_ready) begin is_t.push_back(cyc); is_v.push_back(instr); end
    end
  end

  function automatic bit cond_ok(input logic [2:0] c, input bit z, input bit n);
    case (c)
      3'd0: return 1'b0;
      3'd1: return z;
      3'd2: return n;
      3'd3: return n | z;
      3'd4: return 1'b1;
      3'd5: return !z;
      3'd6: return !n && !z;
      default: return !n;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_t.delete(); rd_a.delete(); jt_t.delete(); is_t.delete(); is_v.delete();
    iv_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b1; flag_we = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_pc = 8'h00;
  endtask

  task automatic set_flags(input logic [7:0] v);
    flag_we = 1'b1; alu_result = v;
    tick();
    flag_we = 1'b0;
  endtask

  // One instruction from IDLE, then park.
  task automatic step();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (8) tick();
  endtask

  task automatic goto_pc(input logic [7:0] tgt);
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    mem[m_pc] = 8'hC4;
    mem[nxt]  = tgt;
    step();
    m_pc = tgt;
  endtask

  task automatic exec_jump(input logic [7:0] op, output logic [7:0] tgt);
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    tgt = m_pc + 8'd3 + 8'($urandom_range(0, 250));
    mem[m_pc] = op;
    mem[nxt]  = tgt;
    clear_logs();
    step();
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    tick();
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++;
    if (jump_taken !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b want 0", jump_taken); end
    checks++;
    if (instr !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h want 00", instr); end
    checks++;
    rst_n = 1'b1;
    m_pc = 8'h00;
    clear_logs();
    repeat (5) tick();
    if (rd_t.size() != 0) begin errors++; $display("FAIL idle_reads: got %0d want 0", rd_t.size()); end
    checks++;
    // Z resets to 1, so a jump-if-zero is taken straight out of reset.
    mem[0] = 8'hC1; mem[1] = 8'h20;
    clear_logs();
    step();
    if (pc !== 8'h20) begin errors++; $display("FAIL reset_zflag_pc: got %h want 20", pc); end
    checks++;
    if (jt_t.size() != 1) begin errors++; $display("FAIL reset_zflag_pulse: got %0d want 1", jt_t.size()); end
    checks++;
    m_pc = 8'h20;
  endtask

  task automatic test_backpressure();
    do_reset();
    mem[0] = 8'h12;
    clear_logs();
    instr_ready = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) instr_ready = 1'b1;
      if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, instr_valid); end
      checks++;
      if (instr !== 8'h12) begin errors++; $display("FAIL bp_instr[%0d]: got %h want 12", k, instr); end
      checks++;
      if (pc !== 8'h00) begin errors++; $display("FAIL bp_pc[%0d]: got %h want 00", k, pc); end
      checks++;
      tick();
    end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", instr_valid); end
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL bp_pc_after: got %h want 01", pc); end
    checks++;
    if (iv_cnt != 4) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 4", iv_cnt); end
    checks++;
    if (is_v.size() != 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", is_v.size()); end
    checks++;
    repeat (6) tick();
    m_pc = 8'h01;
  endtask

  task automatic test_taken();
    goto_pc(8'h04);
    set_flags(8'h00);
    mem[4] = 8'hC1; mem[5] = 8'h40;
    clear_logs();
    step();
    if (pc !== 8'h40) begin errors++; $display("FAIL taken_pc: got %h want 40", pc); end
    checks++;
    if (rd_a.size() != 2) begin errors++; $display("FAIL taken_nreads: got %0d want 2", rd_a.size()); end
    checks++;
    if (rd_a.size() == 2) begin
      if (rd_a[0] !== 8'h04 || rd_a[1] !== 8'h05) begin
        errors++; $display("FAIL taken_addrs: got %h,%h want 04,05", rd_a[0], rd_a[1]);
      end
      checks++;
      if (rd_t[1] - rd_t[0] != 2) begin errors++; $display("FAIL taken_spacing: got %0d want 2", rd_t[1] - rd_t[0]); end
      checks++;
    end
    if (jt_t.size() != 1) begin errors++; $display("FAIL taken_pulses: got %0d want 1", jt_t.size()); end
    checks++;
    if (iv_cnt != 0) begin errors++; $display("FAIL taken_valid: got %0d want 0", iv_cnt); end
    checks++;
    m_pc = 8'h40;
  endtask

  task automatic test_not_taken();
    goto_pc(8'h04);
    set_flags(8'h05);
    mem[4] = 8'hC1; mem[5] = 8'h40;
    clear_logs();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (2) tick();
    if (pc !== 8'h06) begin errors++; $display("FAIL nt_pc_latency: got %h want 06", pc); end
    checks++;
    repeat (6) tick();
    if (rd_a.size() != 1 || rd_a[0] !== 8'h04) begin
      errors++; $display("FAIL nt_reads: got %0d reads want one at 04", rd_a.size());
    end
    checks++;
    if (jt_t.size() != 0) begin errors++; $display("FAIL nt_pulses: got %0d want 0", jt_t.size()); end
    checks++;
    if (iv_cnt != 0) begin errors++; $display("FAIL nt_valid: got %0d want 0", iv_cnt); end
    checks++;
    m_pc = 8'h06;
  endtask

  task automatic test_conditions();
    logic [7:0] ops [5];
    bit         exp_tk [5];
    logic [7:0] fl [5];
    logic [7:0] tgt, exp_pc, op;
    bit         tk;
    ops = '{8'hC6, 8'hC2, 8'hC3, 8'hC0, 8'hC4};
    exp_tk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    set_flags(8'h80);
    for (int i = 0; i < 5; i++) begin
      exec_jump(ops[i], tgt);
      exp_pc = exp_tk[i] ? tgt : m_pc + 8'd2;
      if (pc !== exp_pc) begin errors++; $display("FAIL sign_cond op=%h: got pc %h want %h", ops[i], pc, exp_pc); end
      checks++;
      m_pc = exp_pc;
    end
    fl = '{8'h00, 8'h05, 8'h80, 8'h7F, 8'($urandom)};
    for (int f = 0; f < 5; f++) begin
      set_flags(fl[f]);
      for (int c = 0; c < 8; c++) begin
        op = {2'b11, 3'($urandom), 3'(c)};
        tk = cond_ok(3'(c), fl[f] == 8'h00, fl[f][7]);
        exec_jump(op, tgt);
        exp_pc = tk ? tgt : m_pc + 8'd2;
        if (pc !== exp_pc) begin
          errors++; $display("FAIL cond op=%h alu=%h: got pc %h want %h", op, fl[f], pc, exp_pc);
        end
        checks++;
        if (jt_t.size() != int'(tk)) begin
          errors++; $display("FAIL cond_pulse op=%h alu=%h: got %0d want %0d", op, fl[f], jt_t.size(), tk);
        end
        checks++;
        m_pc = exp_pc;
      end
    end
  endtask

  task automatic test_wrap();
    goto_pc(8'hFF);
    mem[8'hFF] = 8'h33;
    clear_logs();
    step();
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap_nonjump: got %h want 00", pc); end
    checks++;
    m_pc = 8'h00;
    goto_pc(8'hFE);
    set_flags(8'h05);
    mem[8'hFE] = 8'hC1;
    step();
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap_not_taken: got %h want 00", pc); end
    checks++;
    m_pc = 8'h00;
    goto_pc(8'hFF);
    mem[8'hFF] = 8'hC4; mem[0] = 8'h77;
    clear_logs();
    step();
    if (rd_a.size() != 2 || rd_a[0] !== 8'hFF || rd_a[1] !== 8'h00) begin
      errors++; $display("FAIL wrap_target_read: got %0d reads want FF then 00", rd_a.size());
    end
    checks++;
    if (pc !== 8'h77) begin errors++; $display("FAIL wrap_taken_pc: got %h want 77", pc); end
    checks++;
    // Z is 0 here; setting it during WAIT_I must not make this jump taken.
    mem[8'h77] = 8'hC1; mem[8'h78] = 8'h10;
    clear_logs();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    flag_we = 1'b1; alu_result = 8'h00;
    tick();
    flag_we = 1'b0;
    repeat (6) tick();
    if (pc !== 8'h79) begin errors++; $display("FAIL flag_timing_pc: got %h want 79", pc); end
    checks++;
    if (jt_t.size() != 0) begin errors++; $display("FAIL flag_timing_pulse: got %0d want 0", jt_t.size()); end
    checks++;
    mem[8'h79] = 8'hC1; mem[8'h7A] = 8'h10;
    step();
    if (pc !== 8'h10) begin errors++; $display("FAIL flag_next_jump: got %h want 10", pc); end
    checks++;
    m_pc = 8'h10;
  endtask

  task automatic test_reset_run();
    mem[m_pc] = 8'h12;
    instr_ready = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (2) tick();
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL rr_in_issue: got %b want 1", instr_valid); end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_async_valid: got %b want 0", instr_valid); end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL rr_async_pc: got %h want 00", pc); end
    checks++;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    if (pc !== 8'h00) begin errors++; $display("FAIL rr_pc_after: got %h want 00", pc); end
    checks++;
    mem[0] = 8'hC4; mem[1] = 8'h30;
    run = 1'b1;
    repeat (3) tick();
    if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin
      errors++; $display("FAIL rr_fetch_t: got rd=%b addr=%h want 1,01", mem_rd, mem_addr);
    end
    checks++;
    run = 1'b0;
    tick();
    if (jump_taken !== 1'b1) begin errors++; $display("FAIL rr_pulse: got %b want 1", jump_taken); end
    checks++;
    tick();
    if (pc !== 8'h30) begin errors++; $display("FAIL rr_jump_pc: got %h want 30", pc); end
    checks++;
    clear_logs();
    repeat (5) tick();
    if (rd_t.size() != 0) begin errors++; $display("FAIL rr_parked: got %0d reads want 0", rd_t.size()); end
    checks++;
    m_pc = 8'h30;
  endtask

  task automatic test_back_to_back();
    bit         rdy [W+8];
    bit         fwe [W+8];
    logic [7:0] alu [W+8];
    bit         zf [W+9];
    bit         nf [W+9];
    int         e_rd_t[$];
    logic [7:0] e_rd_a[$];
    int         e_jt[$];
    int         e_is_t[$];
    logic [7:0] e_is_v[$];
    logic [7:0] b, p, p1;
    int         t, u, cb;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 9) < 4) b[7:6] = 2'b11;
        else if (b[7:6] == 2'b11) b[7:6] = 2'b10;
        mem[a] = b;
      end
      for (int r = 0; r < W + 8; r++) begin
        rdy[r] = ($urandom_range(0, 9) < 7);
        fwe[r] = ($urandom_range(0, 3) == 0);
        alu[r] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      zf[0] = 1'b1; nf[0] = 1'b0;
      for (int k = 0; k < W + 8; k++) begin
        zf[k+1] = fwe[k] ? (alu[k] == 8'h00) : zf[k];
        nf[k+1] = fwe[k] ? alu[k][7] : nf[k];
      end
      e_rd_t.delete(); e_rd_a.delete(); e_jt.delete(); e_is_t.delete(); e_is_v.delete();
      p = 8'h00; t = 1;
      while (t < W) begin
        e_rd_t.push_back(t); e_rd_a.push_back(p);
        b = mem[p];
        p1 = p + 8'd1;
        if (b[7:6] == 2'b11) begin
          if (cond_ok(b[2:0], zf[t+1], nf[t+1])) begin
            if (t + 2 < W) begin e_rd_t.push_back(t + 2); e_rd_a.push_back(p1); end
            if (t + 3 < W) e_jt.push_back(t + 3);
            p = mem[p1];
            t = t + 4;
          end else begin
            p = p + 8'd2;
            t = t + 2;
          end
        end else begin
          u = t + 2;
          while (u < W && !rdy[u]) u++;
          if (u < W) begin e_is_t.push_back(u); e_is_v.push_back(b); end
          p = p1;
          t = u + 1;
        end
      end
      clear_logs();
      cb = cyc;
      for (int r = 0; r < W; r++) begin
        instr_ready = rdy[r]; flag_we = fwe[r]; alu_result = alu[r];
        if (r == 0) run = 1'b1;
        tick();
      end
      rst_n = 1'b0; run = 1'b0; flag_we = 1'b0; instr_ready = 1'b1;
      #1;
      if (pc !== 8'h00 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_reset[%0d]: got pc=%h valid=%b want 00,0", it, pc, instr_valid);
      end
      checks++;
      if (rd_t.size() != e_rd_t.size()) begin
        errors++; $display("FAIL b2b_nreads[%0d]: got %0d want %0d", it, rd_t.size(), e_rd_t.size());
      end
      checks++;
      for (int i = 0; i < e_rd_t.size() && i < rd_t.size(); i++) begin
        if (rd_t[i] - cb != e_rd_t[i] || rd_a[i] !== e_rd_a[i]) begin
          errors++; $display("FAIL b2b_read[%0d.%0d]: got t=%0d a=%h want t=%0d a=%h",
                             it, i, rd_t[i] - cb, rd_a[i], e_rd_t[i], e_rd_a[i]);
        end
        checks++;
      end
      if (jt_t.size() != e_jt.size()) begin
        errors++; $display("FAIL b2b_njumps[%0d]: got %0d want %0d", it, jt_t.size(), e_jt.size());
      end
      checks++;
      for (int i = 0; i < e_jt.size() && i < jt_t.size(); i++) begin
        if (jt_t[i] - cb != e_jt[i]) begin
          errors++; $display("FAIL b2b_jump[%0d.%0d]: got t=%0d want t=%0d", it, i, jt_t[i] - cb, e_jt[i]);
        end
        checks++;
      end
      if (is_t.size() != e_is_t.size()) begin
        errors++; $display("FAIL b2b_nissue[%0d]: got %0d want %0d", it, is_t.size(), e_is_t.size());
      end
      checks++;
      for (int i = 0; i < e_is_t.size() && i < is_t.size(); i++) begin
        if (is_t[i] - cb != e_is_t[i] || is_v[i] !== e_is_v[i]) begin
          errors++; $display("FAIL b2b_issue[%0d.%0d]: got t=%0d v=%h want t=%0d v=%h",
                             it, i, is_t[i] - cb, is_v[i], e_is_t[i], e_is_v[i]);
        end
        checks++;
      end
      repeat (2) tick();
      rst_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_taken();
    test_not_taken();
    test_conditions();
    test_wrap();
    test_reset_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
